// File: rtl/cla_operand_issue.sv
// Operand queue feeding a carry-lookahead adder: buffers {a, b, cin} sets in
// FIFO order, presents the head to the adder, and counts issued sets.
module cla_operand_issue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_cin,
  output logic                     in_ready,
  output logic                     op_valid,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic                     op_cin,
  input  logic                     op_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               issue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_issueCount;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // in_ready depends only on registered level plus flush/reset, never on op_ready,
  // so a full queue refuses a push even on an edge where the head is popped.
  assign w_full   = (r_level == FULL_LEVEL);
  assign w_empty  = (r_level == '0);
  assign in_ready = ~w_full & ~flush & ~reset;
  assign op_valid = ~w_empty;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = op_valid & op_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_issueCount <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr       <= r_rptr + 1'b1;
        r_issueCount <= r_issueCount + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_a, in_b, in_cin};
  end

  assign w_head      = r_mem[r_rptr];
  assign op_a        = op_valid ? w_head[EW-1 -: WIDTH] : '0;
  assign op_b        = op_valid ? w_head[WIDTH:1] : '0;
  assign op_cin      = op_valid ? w_head[0] : 1'b0;
  assign level       = r_level;
  assign issue_count = r_issueCount;

endmodule

// File: tb/tb_cla_operand_issue.sv
// Scoreboard bench for cla_operand_issue: a queue-based model predicts accepted
// operand sets; a monitor checks every presented head against it in order.
module tb_cla_operand_issue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_ready;
  logic             op_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]       issue_count;

  int checks = 0;
  int failures = 0;

  // Reference model: expected queue contents and issue count.
  logic [2*WIDTH:0] sbQ[$];
  int               mdlLevel = 0;
  int               mdlIssue = 0;

  cla_operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .in_ready(in_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_ready(op_ready), .level(level), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one set of inputs and hold them across a single rising edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic rdy, input logic f);
    in_valid = v; in_a = a; in_b = b; in_cin = c; op_ready = rdy; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    in_valid = 0; op_ready = 0; flush = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  // Monitor: head data must match the oldest expected entry; consume on a real pop.
  always @(negedge clk) begin
    if (!reset && op_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("head_unexpected", 32'(op_valid), 32'd0);
      end else begin
        checkOutput("head_data", 32'({op_a, op_b, op_cin}), 32'(sbQ[0]));
        if (op_ready && !flush) void'(sbQ.pop_front());
      end
    end
  end

  // Predictor: compare status against the model, then apply this cycle's edge.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      sbQ.delete();
      mdlLevel = 0;
      mdlIssue = 0;
    end else begin
      checkOutput("level", 32'(level), 32'(mdlLevel));
      checkOutput("op_valid", 32'(op_valid), 32'(mdlLevel != 0));
      checkOutput("in_ready", 32'(in_ready), 32'((mdlLevel != DEPTH) && !flush));
      checkOutput("issue_count", 32'(issue_count), 32'(mdlIssue));
      if (mdlLevel == 0)
        checkOutput("idle_data_zero", 32'({op_a, op_b, op_cin}), 32'd0);
      if (flush) begin
        sbQ.delete();
        mdlLevel = 0;
      end else begin
        automatic bit accept = in_valid && (mdlLevel != DEPTH);
        if (mdlLevel != 0 && op_ready) begin
          mdlLevel--;
          mdlIssue = (mdlIssue + 1) % 256;
        end
        if (accept) begin
          sbQ.push_back({in_a, in_b, in_cin});
          mdlLevel++;
        end
      end
    end
  end

  initial begin
    // Single push into an empty queue: visible the next cycle, no bypass.
    doReset();
    in_valid = 1; in_a = 4'h9; in_b = 4'h6; in_cin = 1; op_ready = 0;
    #1 checkOutput("no_bypass", 32'(op_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 0;
    checkOutput("single_a", 32'(op_a), 32'h9);
    checkOutput("single_b", 32'(op_b), 32'h6);
    checkOutput("single_cin", 32'(op_cin), 32'd1);
    checkOutput("single_level", 32'(level), 32'd1);

    // Fill with back-pressure, refused third push, then drain.
    doReset();
    applyStimulus(1, 4'h1, 4'h2, 0, 0, 0);
    applyStimulus(1, 4'h3, 4'h4, 1, 0, 0);
    checkOutput("full_level", 32'(level), 32'd2);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 4'h5, 4'h6, 1, 1, 0);
    checkOutput("pop_no_push_level", 32'(level), 32'd1);
    checkOutput("after_pop_head", 32'({op_a, op_b, op_cin}), 32'({4'h3, 4'h4, 1'b1}));
    applyStimulus(0, 4'h0, 4'h0, 0, 1, 0);
    applyStimulus(0, 4'h0, 4'h0, 0, 1, 0);
    checkOutput("fill_issue_count", 32'(issue_count), 32'd2);
    checkOutput("drained_level", 32'(level), 32'd0);

    // Streaming for 300 cycles with incrementing a.
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1, WIDTH'(i), 4'hA, i[0], 1, 0);
    in_valid = 0; op_ready = 0;
    checkOutput("stream_issue_wrap", 32'(issue_count), 32'd43);
    checkOutput("stream_level", 32'(level), 32'd1);

    // Flush with push and pop requested: clears, no pop counted, nothing stored.
    doReset();
    applyStimulus(1, 4'h7, 4'h8, 0, 0, 0);
    applyStimulus(1, 4'hB, 4'hC, 1, 0, 0);
    applyStimulus(1, 4'hD, 4'hE, 1, 1, 1);
    applyStimulus(0, 4'h0, 4'h0, 0, 0, 0);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_op_valid", 32'(op_valid), 32'd0);
    checkOutput("flush_issue", 32'(issue_count), 32'd0);

    // Asynchronous reset between edges with one entry queued.
    doReset();
    applyStimulus(1, 4'h2, 4'h3, 0, 1, 0);
    applyStimulus(1, 4'h4, 4'h5, 1, 1, 0);
    in_valid = 0; op_ready = 0;
    checkOutput("pre_reset_level", 32'(level), 32'd1);
    #2 reset = 1;
    #1;
    checkOutput("async_op_valid", 32'(op_valid), 32'd0);
    checkOutput("async_data", 32'({op_a, op_b, op_cin}), 32'd0);
    checkOutput("async_level", 32'(level), 32'd0);
    checkOutput("async_issue", 32'(issue_count), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 reset = 0;
    #1 checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with occasional flushes.
    @(posedge clk); #1;
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    applyStimulus(0, 4'h0, 4'h0, 0, 1, 0);
    applyStimulus(0, 4'h0, 4'h0, 0, 1, 0);
    applyStimulus(0, 4'h0, 4'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_operand_issue.md
CLA_OPERAND_ISSUE -- requirements
Module: cla_operand_issue

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits.
REQ-002 Parameter DEPTH, default 2: operand queue entries; power of two, minimum 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous queue clear.
REQ-006 in_valid  input  1  upstream operand set valid.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in.
REQ-010 in_ready  output  1  block can accept an operand set this cycle.
REQ-011 op_valid  output  1  head operand set presented to the adder.
REQ-012 op_a  output  WIDTH  head operand A.
REQ-013 op_b  output  WIDTH  head operand B.
REQ-014 op_cin  output  1  head carry-in.
REQ-015 op_ready  input  1  adder/result stage consumes the head this cycle.
REQ-016 level  output  clog2(DEPTH)+1  queued entry count.
REQ-017 issue_count  output  8  number of operand sets issued, modulo 256.

Function
REQ-018 Push: occurs on an edge where in_valid=1 and in_ready=1; it stores {in_a, in_b, in_cin} at the tail.
REQ-019 Pop: occurs on an edge where op_valid=1 and op_ready=1; it removes the head.
REQ-020 Ordering: operand sets issue in strict FIFO order, with no loss and no duplication.
REQ-021 in_ready = (level != DEPTH) AND NOT flush AND NOT reset.
- It is a pure function of registered state plus flush/reset.
- It has no combinational path from op_ready or in_valid.
REQ-022 op_valid = (level != 0).
REQ-023 op_a, op_b and op_cin show the head entry while op_valid=1, and are all-zero while op_valid=0.
REQ-024 Latency: a push into an empty queue at edge N gives op_valid=1 with that data in the cycle after edge N; there is no same-cycle bypass.
REQ-025 Simultaneous push and pop with 0 < level < DEPTH: both take effect, and level is unchanged.
REQ-026 Full (level=DEPTH): in_ready=0 and in_valid is ignored.
- A pop-only edge makes in_ready=1 in the next cycle.
- A push in the same cycle as that pop is not accepted.
REQ-027 Empty (level=0): op_ready is ignored; there is no pop and no issue_count change.
REQ-028 Pointers: read and write pointers wrap from DEPTH-1 to 0.
- level is maintained exactly through wrap.
REQ-029 issue_count increments by 1 on every pop and wraps from 255 to 0.
REQ-030 flush=1 at an edge:
- level becomes 0 and both pointers become 0.
- Flush has priority over push and pop; no pop is counted on that edge.
- issue_count is unchanged.
REQ-031 Operand values are opaque: no arithmetic or width conversion is applied to them.

Reset
REQ-032 While reset=1, independent of clk, the outputs take these values:
- level=0, op_valid=0 and op_a/op_b/op_cin=0.
- issue_count=0 and in_ready=0.
- Pointers=0.
REQ-033 Reset asserted mid-operation discards all queued entries; no partial entry survives.
REQ-034 After reset deasserts, in_ready=1 in the first cycle, provided flush=0.
REQ-035 Queue storage contents need no reset; they are never visible while op_valid=0.

Verification
REQ-036 Single push into empty queue:
- Stimulus: reset, then push a=4'h9, b=4'h6, cin=1 with op_ready=0.
- Response: the next cycle shows op_valid=1, op_a=9, op_b=6, op_cin=1, level=1.
REQ-037 Fill with back-pressure:
- Stimulus: DEPTH=2; push (1,2,0) then (3,4,1) with op_ready=0.
- Response: level=2 and in_ready=0; a third push is ignored.
- Then: pop twice with op_ready=1.
- Response: outputs (1,2,0) then (3,4,1); issue_count=2.
REQ-038 Streaming:
- Stimulus: in_valid=1 and op_ready=1 continuously for 300 cycles with incrementing a.
- Response: outputs in order with none dropped; level stays at 1 after the first cycle; issue_count wraps to 299 mod 256 = 43.
REQ-039 Flush:
- Stimulus: level=2, then flush=1 with in_valid=1 and op_ready=1.
- Response: the next cycle shows level=0 and op_valid=0; issue_count is unchanged; the pushed data is not stored.
REQ-040 Asynchronous reset mid-stream:
- Stimulus: with level=1, assert reset between clock edges.
- Response: op_valid, op_a/b/cin, level and issue_count go to 0 immediately.
- After release: in_ready=1 in the first cycle.
